// File: rtl/apb_cmd_master.sv
// APB4 requester: single commands in on valid/ready, one SETUP/ACCESS transfer out, response back on valid/ready.
// Optional ACCESS timeout is compiled in with `define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_BIT = 12,
  parameter int TIMEOUT = 64
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  // Handshake rule on both channels: a beat transfers on the rising PCLK edge where valid and
  // ready are both high; rsp_valid with its payload is held stable until rsp_ready is seen.
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_strb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   PADDR,
  output logic [1:0]      PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [DW-1:0]   PWDATA,
  output logic [DW/8-1:0] PSTRB,
  output logic [2:0]      PPROT,
  input  logic            PREADY,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PSLVERR,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]   paddr_q,  paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW/8-1:0] pstrb_q,  pstrb_d;
  logic            sel_q,    sel_d;
  logic [DW-1:0]   rdata_q,  rdata_d;
  logic            err_q,    err_d;

  logic accept;
  logic dec_err;
  logic acc_tmo;

  assign accept  = cmd_valid && (state_q == ST_IDLE);
  // Any address bit above the slave-select bit set means no slave owns the address.
  assign dec_err = |(cmd_addr >> (SEL_BIT + 1));

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Fires on the TIMEOUT-th consecutive ACCESS cycle without PREADY; PREADY on that cycle still wins.
  assign acc_tmo = (state_q == ST_ACCESS) && !PREADY && (tmo_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_ACCESS && !PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign acc_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = dec_err ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY || acc_tmo) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 2'b00;
    PENABLE   = 1'b0;
    case (state_q)
      ST_IDLE:   cmd_ready = 1'b1;
      ST_SETUP:  PSEL = sel_q ? 2'b10 : 2'b01;
      ST_ACCESS: begin
        PSEL    = sel_q ? 2'b10 : 2'b01;
        PENABLE = 1'b1;
      end
      ST_RESP:   rsp_valid = 1'b1;
      default:   cmd_ready = 1'b0;
    endcase
  end

  // APB request fields only change on a decodable accept, so they hold outside a transfer.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      if (dec_err) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        paddr_d  = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_wdata;
        pstrb_d  = cmd_write ? cmd_strb : '0;
        sel_d    = cmd_addr[SEL_BIT];
      end
    end
    if (state_q == ST_ACCESS) begin
      if (PREADY) begin
        err_d   = PSLVERR;
        rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
      end else if (acc_tmo) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      sel_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = 3'b000;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, hand-written corner sequences and random traffic.
`timescale 1ns/1ps
module tb_apb_cmd_master;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SEL_BIT = 12;
  localparam int TIMEOUT = 64;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            PCLK, PRESETn;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_strb;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   PADDR;
  logic [1:0]      PSEL;
  logic            PENABLE, PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]      PPROT;
  logic            PREADY, PSLVERR;
  logic [DW-1:0]   PRDATA;
  logic [1:0]      dbg_state;

  apb_cmd_master #(.AW(AW), .DW(DW), .SEL_BIT(SEL_BIT), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic            write;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] strb;
    int              waits;
    int              hold;
    logic [DW-1:0]   rdata;
    logic            slverr;
    logic [1:0]      exp_psel;
    logic [DW/8-1:0] exp_pstrb;
    int              exp_lat;
    logic [DW-1:0]   exp_rdata;
    logic            exp_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: expectations from the protocol rules, independent of the DUT's structure.
  function automatic vec_t model(input vec_t v);
    vec_t       r;
    bit         dec;
    bit         tmo;
    logic [AW-1:0] a;
    r   = v;
    a   = v.addr;
    dec = (a >> (SEL_BIT + 1)) != 0;
    tmo = TMO_EN && (v.waits >= TIMEOUT);
    r.exp_psel  = dec ? 2'b00 : (a[SEL_BIT] ? 2'b10 : 2'b01);
    r.exp_pstrb = v.write ? v.strb : '0;
    r.exp_lat   = dec ? 1 : (tmo ? 2 + TIMEOUT : 3 + v.waits);
    r.exp_err   = dec || tmo || v.slverr;
    r.exp_rdata = (r.exp_err || v.write) ? '0 : v.rdata;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"},   rsp_err,   0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_psel"},      PSEL,      0);
    check({tag, "_penable"},   PENABLE,   0);
    check({tag, "_paddr"},     PADDR,     0);
    check({tag, "_pwrite"},    PWRITE,    0);
    check({tag, "_pwdata"},    PWDATA,    0);
    check({tag, "_pstrb"},     PSTRB,     0);
  endtask

  // Driver: runs one command end to end, playing the slave with v.waits wait states.
  task automatic run_txn(input vec_t v);
    int         k;
    bit         seen;
    bit         dec;
    logic [DW:0] e;
    dec = (v.exp_psel == 2'b00);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    check("cmd_ready_idle", cmd_ready, 1);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge PCLK);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge PCLK);
      k++;
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      PRDATA    = $urandom;
      PSLVERR   = 1'($urandom_range(0, 1));
      if (rsp_valid) begin
        seen = 1'b1;
      end else if (!dec) begin
        check("psel_xfer",    PSEL,    v.exp_psel);
        check("penable_xfer", PENABLE, (k >= 2) ? 1 : 0);
        check("paddr_xfer",   PADDR,   v.addr);
        check("pwrite_xfer",  PWRITE,  v.write);
        check("pwdata_xfer",  PWDATA,  v.wdata);
        check("pstrb_xfer",   PSTRB,   v.exp_pstrb);
        check("cmd_ready_busy", cmd_ready, 0);
        if (k == 2 + v.waits) begin
          PREADY  = 1'b1;
          PRDATA  = v.rdata;
          PSLVERR = v.slverr;
        end
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("rsp_valid_timeout", 0, 1);
      do_reset();
      return;
    end
    check("rsp_latency", k, v.exp_lat);
    for (int d = 0; ; d++) begin
      check("rsp_valid_hold", rsp_valid, 1);
      check("rsp_rdata",      rsp_rdata, e[DW-1:0]);
      check("rsp_err",        rsp_err,   e[DW]);
      check("psel_resp",      {PSEL, PENABLE}, 0);
      check("cmd_ready_resp", cmd_ready, 0);
      if (d >= v.hold) begin
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        break;
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom_range(0, 32'h1FFF);
      @(negedge PCLK);
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_valid_done", rsp_valid, 0);
    check("cmd_ready_done", cmd_ready, 1);
    check("psel_done",      {PSEL, PENABLE}, 0);
    if (!dec) check("paddr_held", PADDR, v.addr);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   k;
  bit   seen;

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    //        wr    addr           wdata          strb  wt  hd  rdata          sl    psel   pstrb lat rsp_rdata      err
    tbl[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0,  0, 32'h0,         1'b0, 2'b01, 4'hF, 3,  32'h0,         1'b0};
    tbl[1] = '{1'b0, 32'h0000_1008, 32'h0,         4'hF, 2,  1, 32'h1234_5678, 1'b0, 2'b10, 4'h0, 5,  32'h1234_5678, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1,  3, 32'h55AA_55AA, 1'b1, 2'b01, 4'h0, 4,  32'h0,         1'b1};
    tbl[3] = '{1'b1, 32'h0000_2000, 32'h1111_1111, 4'hF, 0,  0, 32'h0,         1'b0, 2'b00, 4'h0, 1,  32'h0,         1'b1};
    tbl[4] = '{1'b1, 32'h0000_1ABC, 32'hCAFE_F00D, 4'h5, 3,  0, 32'h9999_9999, 1'b1, 2'b10, 4'h5, 6,  32'h0,         1'b1};
    tbl[5] = '{1'b0, 32'h0000_1FFC, 32'h0,         4'h0, 63, 0, 32'hAABB_CCDD, 1'b0, 2'b10, 4'h0, 66, 32'hAABB_CCDD, 1'b0};
    tbl[6] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0,  0, 32'h0,         1'b0, 2'b00, 4'h0, 1,  32'h0,         1'b1};
    tbl[7] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 0,  2, 32'h0BAD_F00D, 1'b0, 2'b01, 4'h0, 3,  32'h0BAD_F00D, 1'b0};

    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_reset_values("reset");
    check("reset_pprot", PPROT, 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Reset during ACCESS discards the transfer and its response.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0004;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("midrst_penable_before", PENABLE, 1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_reset_values("midrst");
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    check("midrst_no_rsp", rsp_valid, 0);
    check("midrst_no_psel", PSEL, 0);

    // Slave that never answers.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
    @(posedge PCLK);
    k = 0; seen = 1'b0;
    while (!seen && k < 1000) begin
      @(negedge PCLK);
      k++;
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    check("tmo_seen",    seen, 1);
    check("tmo_latency", k, 2 + TIMEOUT);
    check("tmo_err",     rsp_err, 1);
    check("tmo_rdata",   rsp_rdata, 0);
    check("tmo_psel",    {PSEL, PENABLE}, 0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("tmo_cmd_ready", cmd_ready, 1);
`else
    check("stuck_no_rsp",     seen, 0);
    check("stuck_penable",    PENABLE, 1);
    check("stuck_psel",       PSEL, 2'b01);
    do_reset();
    @(negedge PCLK);
    check("stuck_recover", cmd_ready, 1);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      rv.write  = 1'($urandom_range(0, 1));
      rv.addr   = $urandom_range(0, 32'h1FFF);
      if ($urandom_range(0, 9) == 0) rv.addr = rv.addr | ($urandom << (SEL_BIT + 1)) | 32'h8000_0000;
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom_range(0, 15));
      rv.waits  = $urandom_range(0, 4);
      rv.hold   = $urandom_range(0, 2);
      rv.rdata  = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      run_txn(model(rv));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
